// File: rtl/ft245_pkg.sv
// Shared types and helpers for the FT245 synchronous-FIFO transmitter.
// With FT_FRAME_HDR_EN defined, the state enum also carries the header states.
package ft245_pkg;

    localparam int FT_BYTE_W = 8;
    localparam int SAMPLE_W  = 16;

    localparam logic [SAMPLE_W-1:0] HDR_WORD_DEF = 16'hA55A;

`ifdef FT_FRAME_HDR_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BYTE0 = 3'd1,
        ST_BYTE1 = 3'd2,
        ST_HDR0  = 3'd3,
        ST_HDR1  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2
    } state_t;
`endif

    // Pick the byte of a word that goes out first (second=0) or second (second=1).
    function automatic logic [FT_BYTE_W-1:0] sel_byte(
        input logic [SAMPLE_W-1:0] word,
        input logic                msb_first,
        input logic                second
    );
        sel_byte = (msb_first ^ second) ? word[SAMPLE_W-1:FT_BYTE_W]
                                        : word[FT_BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/ft245_tx.sv
// FT245 synchronous-mode transmitter: pops 16-bit samples from an FWFT FIFO
// and writes them as byte pairs using the TXE#/WR# handshake, back to back.
// Optional macro FT_FRAME_HDR_EN: prefix every frame with HDR_WORD.
module ft245_tx
    import ft245_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 8,
    parameter int MSB_FIRST       = 0
`ifdef FT_FRAME_HDR_EN
    ,
    parameter logic [SAMPLE_W-1:0] HDR_WORD = HDR_WORD_DEF
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic [SAMPLE_W-1:0]  fifo_data_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_o,
    input  logic                 ft_txe_i,
    output logic                 ft_wr_o,
    output logic [FT_BYTE_W-1:0] ft_data_o,
    output logic                 busy_o,
    output logic [31:0]          byte_cnt_o,
    output logic [15:0]          frame_cnt_o
);

    localparam logic [7:0] LAST_IDX = 8'(WORDS_PER_FRAME - 1);
    localparam logic       MSB      = (MSB_FIRST != 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [SAMPLE_W-1:0]   r_word;
    logic                  r_wr_n;
    logic [FT_BYTE_W-1:0]  r_data;
    logic [31:0]           r_byte_cnt;
    logic [15:0]           r_frame_cnt;
    logic [7:0]            r_word_idx;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_pop;
    logic                  w_wr_n_nxt;
    logic [FT_BYTE_W-1:0]  w_data_nxt;

    assign w_start     = !fifo_empty_i && en_i;
    assign w_accept    = !r_wr_n && !ft_txe_i;
    assign w_last_word = (r_word_idx == LAST_IDX);

`ifdef FT_FRAME_HDR_EN
    // Set once the header of a new frame has gone out but its first word has
    // not been popped yet, so a restart from IDLE does not resend the header.
    logic r_hdr_sent;
    logic w_hdr_idle;
    logic w_hdr_next;
    assign w_hdr_idle = (r_word_idx == 8'd0) && !r_hdr_sent;
    assign w_hdr_next = w_last_word;

    // Track whether the current frame header is already on the wire.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_hdr_sent <= 1'b0;
        else if (w_pop)
            r_hdr_sent <= 1'b0;
        else if (r_state == ST_HDR1 && w_accept)
            r_hdr_sent <= 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic; a word only starts when data is present and enabled.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
`ifdef FT_FRAME_HDR_EN
                    w_next_state = w_hdr_idle ? ST_HDR0 : ST_BYTE0;
`else
                    w_next_state = ST_BYTE0;
`endif
                end
            end
            ST_BYTE0: if (w_accept) w_next_state = ST_BYTE1;
            ST_BYTE1: begin
                if (w_accept) begin
                    if (!w_start)
                        w_next_state = ST_IDLE;
`ifdef FT_FRAME_HDR_EN
                    else if (w_hdr_next)
                        w_next_state = ST_HDR0;
`endif
                    else
                        w_next_state = ST_BYTE0;
                end
            end
`ifdef FT_FRAME_HDR_EN
            ST_HDR0: if (w_accept) w_next_state = ST_HDR1;
            ST_HDR1: if (w_accept) w_next_state = w_start ? ST_BYTE0 : ST_IDLE;
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: pop strobe plus next WR#/data for the output registers.
    always_comb begin
        w_pop      = 1'b0;
        w_wr_n_nxt = r_wr_n;
        w_data_nxt = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_wr_n_nxt = 1'b0;
`ifdef FT_FRAME_HDR_EN
                    if (w_hdr_idle) begin
                        w_data_nxt = sel_byte(HDR_WORD, MSB, 1'b0);
                    end else begin
                        w_pop      = 1'b1;
                        w_data_nxt = sel_byte(fifo_data_i, MSB, 1'b0);
                    end
`else
                    w_pop      = 1'b1;
                    w_data_nxt = sel_byte(fifo_data_i, MSB, 1'b0);
`endif
                end
            end
            ST_BYTE0: begin
                if (w_accept)
                    w_data_nxt = sel_byte(r_word, MSB, 1'b1);
            end
            ST_BYTE1: begin
                if (w_accept) begin
                    if (!w_start) begin
                        w_wr_n_nxt = 1'b1;
`ifdef FT_FRAME_HDR_EN
                    end else if (w_hdr_next) begin
                        w_data_nxt = sel_byte(HDR_WORD, MSB, 1'b0);
`endif
                    end else begin
                        w_pop      = 1'b1;
                        w_data_nxt = sel_byte(fifo_data_i, MSB, 1'b0);
                    end
                end
            end
`ifdef FT_FRAME_HDR_EN
            ST_HDR0: begin
                if (w_accept)
                    w_data_nxt = sel_byte(HDR_WORD, MSB, 1'b1);
            end
            ST_HDR1: begin
                if (w_accept) begin
                    if (w_start) begin
                        w_pop      = 1'b1;
                        w_data_nxt = sel_byte(fifo_data_i, MSB, 1'b0);
                    end else begin
                        w_wr_n_nxt = 1'b1;
                    end
                end
            end
`endif
            default: w_wr_n_nxt = 1'b1;
        endcase
        // A pop during reset would be lost by the datapath, so suppress it.
        if (reset_i)
            w_pop = 1'b0;
    end

    // Output registers, word latch and counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_n      <= 1'b1;
            r_data      <= '0;
            r_word      <= '0;
            r_byte_cnt  <= '0;
            r_frame_cnt <= '0;
            r_word_idx  <= '0;
        end else begin
            r_wr_n <= w_wr_n_nxt;
            r_data <= w_data_nxt;
            if (w_pop)
                r_word <= fifo_data_i;
            if (w_accept)
                r_byte_cnt <= r_byte_cnt + 32'd1;
            if (w_accept && r_state == ST_BYTE1) begin
                if (w_last_word) begin
                    r_word_idx  <= 8'd0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_word_idx  <= r_word_idx + 8'd1;
                end
            end
        end
    end

    assign fifo_rd_o   = w_pop;
    assign ft_wr_o     = r_wr_n;
    assign ft_data_o   = r_data;
    assign busy_o      = (r_state != ST_IDLE);
    assign byte_cnt_o  = r_byte_cnt;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: doc/ft245_tx.md
Name: ft245_tx

Overview:
- Downstream stage of the DAQ sample FIFO; runs entirely in the FT2232H 60 MHz clock domain.
- Pops 16-bit samples from a first-word-fall-through FIFO read port and serialises each into two bytes.
- Writes the bytes to the FT2232H synchronous FT245 interface using the ft_txe_i / ft_wr_o handshake.
- Words are never split across a stop. Frame boundaries are tracked so the host can realign to 8-channel scans.

Parameters:
- WORDS_PER_FRAME, 8: words per frame (one per ADC channel); legal range 1..256.
- MSB_FIRST, 0: 0 sends the low byte first; 1 sends the high byte first.
- HDR_WORD, 16'hA55A: header value; used only with the optional feature.

Ports:
- clk_i  in  1  60 MHz clock from FT2232H CLKOUT.
- reset_i  in  1  synchronous reset, active-high.
- en_i  in  1  enable; sampled only at word boundaries.
- fifo_data_i  in  16  FWFT head word; valid while fifo_empty_i=0.
- fifo_empty_i  in  1  upstream FIFO empty.
- fifo_rd_o  out  1  pop strobe; combinational, one cycle per word.
- ft_txe_i  in  1  FT2232H TXE#, active-low.
- ft_wr_o  out  1  FT2232H WR#, active-low; registered.
- ft_data_o  out  8  byte to FT2232H; registered.
- busy_o  out  1  high whenever state is not IDLE.
- byte_cnt_o  out  32  count of accepted bytes; wraps at 2^32.
- frame_cnt_o  out  16  count of completed frames; wraps.

Behaviour:
- Reset values: ft_wr_o=1, ft_data_o=0, fifo_rd_o=0, busy_o=0, all counters=0, word_idx=0, state=IDLE.
- Acceptance: a byte is accepted at a rising edge where ft_wr_o=0 and ft_txe_i=0 (both sampled at that edge).
  - If ft_txe_i=1 at that edge, the byte is not accepted: ft_data_o holds, ft_wr_o stays 0.
- States: IDLE, BYTE0, BYTE1 (plus HDR0 and HDR1 with the optional feature).
- Word start condition ("start"): fifo_empty_i=0 and en_i=1.
- IDLE:
  - On start, assert fifo_rd_o for that cycle.
  - At the same edge latch fifo_data_i into word_r, load first byte into ft_data_o, set ft_wr_o=0, go to BYTE0.
  - Latency from non-empty to ft_wr_o low: 1 cycle.
- BYTE0: on acceptance, load second byte into ft_data_o and go to BYTE1.
- BYTE1, on acceptance:
  - byte_cnt_o increments (it increments on every accepted byte).
  - word_idx increments; at WORDS_PER_FRAME-1 it wraps to 0 and frame_cnt_o increments.
  - If start holds in this cycle, pop the next word in the same cycle and go to BYTE0. No bubble: sustained rate is 1 byte per clock.
  - Otherwise set ft_wr_o=1 and go to IDLE.
- Byte order: MSB_FIRST=0 sends [7:0] then [15:8]; MSB_FIRST=1 sends the reverse.
- en_i falling mid-word: the current word completes both bytes; no new pop follows.
- FIFO empty mid-frame: return to IDLE with word_idx preserved; the frame resumes when data arrives.
- fifo_rd_o is never asserted when fifo_empty_i=1.
- reset_i mid-word: the in-flight byte is dropped; ft_wr_o=1 at the next edge; word_idx clears.
- ft_txe_i held high indefinitely: outputs hold, no pop, no counter change.

Optional Feature:
- Macro: FT_FRAME_HDR_EN.
- Defined: when a word is about to start and word_idx=0, the block first sends HDR_WORD as two bytes (same byte order) via states HDR0 and HDR1.
  - The FIFO is not popped until HDR1 is accepted; the pop then follows the normal IDLE/BYTE1 rules.
  - Header bytes count in byte_cnt_o.
  - The header is only started when start is true.
- Undefined: the HDR states and HDR_WORD logic are absent; the byte stream is pure sample data.

Decomposition:
- Package ft245_pkg holds:
  - the state enum;
  - FT_BYTE_W=8 and SAMPLE_W=16;
  - the default HDR_WORD constant;
  - a function that selects the first or second byte given MSB_FIRST.
- No sub-module is needed; counters and the FSM live in one module.

Test Plan:
- Single word 16'h1234, txe low, MSB_FIRST=0: fifo_rd_o pulses once; ft_data_o shows 8'h34 then 8'h12 with ft_wr_o=0 for exactly 2 cycles; byte_cnt_o=2.
- 16 queued words, txe low: 32 consecutive cycles with ft_wr_o=0, 16 pops, no gaps; frame_cnt_o=2.
- Word 16'hBEEF with ft_txe_i high for 5 cycles during byte 8'hEF: ft_data_o holds 8'hEF; byte_cnt_o is unchanged until txe falls; then 8'hBE follows.
- en_i dropped right after the BYTE0 edge with 4 words queued: 8'hBE still completes; no further pop; busy_o=0 one cycle later.
- reset_i during BYTE1: next cycle ft_wr_o=1, counters=0. Afterwards the next word starts with its first byte and word_idx=0.
- With FT_FRAME_HDR_EN, 8 words 16'h0000..16'h0007: stream is A5?? per MSB_FIRST order, i.e. 5A,A5 then 00,00,01,00,…,07,00; byte_cnt_o=18; frame_cnt_o=1.
